// File: rtl/aes_mask_refresh_pkg.sv
// Shared types and sizes for the masked S-box mask refresh controller.
package aes_mask_refresh_pkg;

  localparam int NUM_BYTES = 16;
  localparam int MASK_W    = 8 * NUM_BYTES;

  typedef logic [7:0] mask_byte_t;
  typedef mask_byte_t mask_vec_t [0:NUM_BYTES-1];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_COMMIT,
    ST_WAIT_DONE,
    ST_READY
  } mask_fsm_e;

endpackage

// File: rtl/aes_mask_refresh_ent_word_filter.sv
// Entropy word screen: flags words containing a zero byte and splits the
// handshake into an accept strobe and a reject strobe.
module aes_ent_word_filter
  import aes_mask_refresh_pkg::*;
#(
  parameter int ENT_W       = 32,
  parameter bit REJECT_ZERO = 1'b1
) (
  input  logic             valid,
  input  logic             ready,
  input  logic [ENT_W-1:0] data,
  output logic             accept,
  output logic             reject
);

  logic has_zero;

  always_comb begin
    has_zero = 1'b0;
    for (int i = 0; i < ENT_W / 8; i++) begin
      if (data[8*i +: 8] == mask_byte_t'(0)) has_zero = 1'b1;
    end
  end

  // A zero mask byte would leave that S-box byte effectively unmasked.
  assign accept = valid && ready && !(REJECT_ZERO && has_zero);
  assign reject = valid && ready && REJECT_ZERO && has_zero;

endmodule

// File: rtl/aes_mask_refresh.sv
// Draws entropy, assembles 16 combined mask bytes, commits them atomically and
// sequences the table precompute stage (start pulse, done wait with timeout).
module aes_mask_refresh
  import aes_mask_refresh_pkg::*;
#(
  parameter int ENT_W       = 32,
  parameter bit REJECT_ZERO = 1'b1,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              refresh_req_i,
  input  logic              enc_dec_i,
  input  logic              ent_valid_i,
  input  logic [ENT_W-1:0]  ent_data_i,
  output logic              ent_ready_o,
  output logic [MASK_W-1:0] mc_o,
  output logic              enc_dec_o,
  output logic              pc_start_o,
  input  logic              pc_done_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [7:0]        rej_cnt_o
);

  localparam int NUM_WORDS = MASK_W / ENT_W;
  localparam int WCW       = $clog2(NUM_WORDS) + 1;
  localparam int TW        = $clog2(TIMEOUT + 1);

  mask_fsm_e         state_q, state_d;
  logic [WCW-1:0]    wcnt_q;
  logic [TW-1:0]     tmo_q;
  logic [MASK_W-1:0] staging_q, staging_d;
  logic              dir_q;
  logic              accept, reject;
  logic              req_take, last_word, done_ok, tmo_last;
  logic              busy_d, ready_d, start_d, ent_rdy_d;

  aes_ent_word_filter #(
    .ENT_W       (ENT_W),
    .REJECT_ZERO (REJECT_ZERO)
  ) u_filter (
    .valid  (ent_valid_i),
    .ready  (ent_ready_o),
    .data   (ent_data_i),
    .accept (accept),
    .reject (reject)
  );

  assign req_take  = refresh_req_i && (state_q == ST_IDLE || state_q == ST_READY);
  assign last_word = accept && (wcnt_q == WCW'(NUM_WORDS - 1));
  // Done is untrusted in the first WAIT_DONE cycle (tmo_q == 0).
  assign done_ok   = (state_q == ST_WAIT_DONE) && (tmo_q != '0) && pc_done_i;
  assign tmo_last  = (state_q == ST_WAIT_DONE) && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: if (refresh_req_i) state_d = ST_COLLECT;
      ST_COLLECT:        if (last_word) state_d = ST_COMMIT;
      ST_COMMIT:         state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_ok)       state_d = ST_READY;
        else if (tmo_last) state_d = ST_IDLE;
      end
      default:           state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so they are glitch-free.
  always_comb begin
    busy_d    = (state_d == ST_COLLECT) || (state_d == ST_COMMIT) || (state_d == ST_WAIT_DONE);
    ready_d   = (state_d == ST_READY);
    start_d   = (state_d == ST_COMMIT);
    ent_rdy_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      ready_o     <= 1'b0;
      pc_start_o  <= 1'b0;
      ent_ready_o <= 1'b0;
    end else begin
      busy_o      <= busy_d;
      ready_o     <= ready_d;
      pc_start_o  <= start_d;
      ent_ready_o <= ent_rdy_d;
    end
  end

  always_comb begin
    staging_d = staging_q;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (wcnt_q == WCW'(w)) staging_d[w*ENT_W +: ENT_W] = ent_data_i;
    end
  end

  // mc_o/enc_dec_o load on the edge into COMMIT so they are valid alongside pc_start_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q    <= '0;
      tmo_q     <= '0;
      staging_q <= '0;
      dir_q     <= 1'b0;
      mc_o      <= '0;
      enc_dec_o <= 1'b0;
      error_o   <= 1'b0;
      rej_cnt_o <= 8'd0;
    end else begin
      if (req_take) begin
        wcnt_q    <= '0;
        rej_cnt_o <= 8'd0;
        error_o   <= 1'b0;
        dir_q     <= enc_dec_i;
      end
      if (accept) begin
        wcnt_q    <= wcnt_q + WCW'(1);
        staging_q <= staging_d;
      end
      if (reject && rej_cnt_o != 8'hFF) rej_cnt_o <= rej_cnt_o + 8'd1;
      if (last_word) begin
        mc_o      <= staging_d;
        enc_dec_o <= dir_q;
      end
      if (state_q == ST_COMMIT)         tmo_q <= '0;
      else if (state_q == ST_WAIT_DONE) tmo_q <= tmo_q + TW'(1);
      if (tmo_last && !done_ok) error_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_mask_refresh.sv
// Directed bench for aes_mask_refresh: collection, rejects, gaps, timeout, ignored requests, async reset.
module tb_aes_mask_refresh;

  localparam int TIMEOUT = 64;

  localparam logic [127:0] MC1  = 128'h100F0E0D_0C0B0A09_08070605_04030201;
  localparam logic [127:0] MC2  = 128'hD4D3D2D1_C4C3C2C1_B4B3B2B1_A4A3A2A1;
  localparam logic [127:0] MC2B = 128'h100F0E0D_0C0B0A09_11002233_04030201;
  localparam logic [127:0] MC3  = 128'h403F3E3D_3C3B3A39_38373635_34333231;
  localparam logic [127:0] MC4  = 128'h605F5E5D_5C5B5A59_58575655_54535251;
  localparam logic [127:0] MC5  = 128'h706F6E6D_6C6B6A69_68676665_64636261;
  localparam logic [127:0] MC6  = 128'h807F7E7D_7C7B7A79_78777675_74737271;
  localparam logic [127:0] MC7  = 128'h908F8E8D_8C8B8A89_88878685_84838281;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req, enc, valid, done;
  logic [31:0]  data;
  logic         ent_ready, enc_o, start, ready, busy, err;
  logic [127:0] mc;
  logic [7:0]   rej;

  logic         req2, valid2;
  logic [31:0]  data2;
  logic         ent_ready2, enc_o2, start2, ready2, busy2, err2;
  logic [127:0] mc2;
  logic [7:0]   rej2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  aes_mask_refresh #(.ENT_W(32), .REJECT_ZERO(1'b1), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .refresh_req_i(req), .enc_dec_i(enc),
    .ent_valid_i(valid), .ent_data_i(data), .ent_ready_o(ent_ready),
    .mc_o(mc), .enc_dec_o(enc_o), .pc_start_o(start), .pc_done_i(done),
    .ready_o(ready), .busy_o(busy), .error_o(err), .rej_cnt_o(rej)
  );

  aes_mask_refresh #(.ENT_W(32), .REJECT_ZERO(1'b0), .TIMEOUT(TIMEOUT)) dut_nz (
    .clk(clk), .rst_n(rst_n), .refresh_req_i(req2), .enc_dec_i(1'b0),
    .ent_valid_i(valid2), .ent_data_i(data2), .ent_ready_o(ent_ready2),
    .mc_o(mc2), .enc_dec_o(enc_o2), .pc_start_o(start2), .pc_done_i(1'b0),
    .ready_o(ready2), .busy_o(busy2), .error_o(err2), .rej_cnt_o(rej2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    valid = 1'b1;
    data  = w;
    tick();
    valid = 1'b0;
  endtask

  task automatic send4(input logic [127:0] m);
    for (int i = 0; i < 4; i++) send(m[32*i +: 32]);
  endtask

  task automatic finish_fill();
    int n = 0;
    done = 1'b1;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_after_done", ready, 1);
    done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; enc = 1'b0; valid = 1'b0; done = 1'b0; data = '0;
    req2 = 1'b0; valid2 = 1'b0; data2 = '0;
    repeat (2) tick();
    chk("rst_mc", mc, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rej", rej, 0);
    chk("rst_ent_ready", ent_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_enc", enc_o, 0);
    rst_n = 1'b1;
    tick();

    // Basic refresh with back-to-back entropy
    req = 1'b1; tick(); req = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ent_ready", ent_ready, 1);
    chk("t1_ready_low", ready, 0);
    send(32'h04030201); send(32'h08070605); send(32'h0C0B0A09);
    chk("t1_mc_hold", mc, 0);
    send(32'h100F0E0D);
    chk("t1_ent_ready_off", ent_ready, 0);
    chk("t1_start", start, 1);
    chk("t1_mc", mc, MC1);
    done = 1'b1;
    tick();
    chk("t1_start_single", start, 0);
    tick();
    chk("t1_done_ignored", ready, 0);
    chk("t1_busy_wait", busy, 1);
    tick();
    chk("t1_ready", ready, 1);
    chk("t1_busy_off", busy, 0);
    done = 1'b0;

    // Zero-byte word rejected and does not consume a slot
    req = 1'b1; tick(); req = 1'b0;
    chk("t2_ready_drop", ready, 0);
    chk("t2_rej_clear", rej, 0);
    send(32'hA4A3A2A1); send(32'h11002233);
    chk("t2_rej_cnt", rej, 1);
    chk("t2_mc_hold", mc, MC1);
    send(32'hB4B3B2B1); send(32'hC4C3C2C1);
    chk("t2_still_collect", ent_ready, 1);
    send(32'hD4D3D2D1);
    chk("t2_mc", mc, MC2);
    chk("t2_start", start, 1);
    finish_fill();

    // REJECT_ZERO=0 instance keeps the zero-byte word in bytes 4..7
    req2 = 1'b1; tick(); req2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid2 = 1'b1; data2 = MC2B[32*i +: 32]; tick();
    end
    valid2 = 1'b0;
    chk("t2b_mc", mc2, MC2B);
    chk("t2b_rej", rej2, 0);
    chk("t2b_start", start2, 1);

    // Gapped entropy: one valid cycle in three, junk on data while invalid
    req = 1'b1; tick(); req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; data = MC3[32*i +: 32]; tick();
      valid = 1'b0; data = 32'hFFFFFFFF; tick(); tick();
    end
    chk("t3_mc_hold", mc, MC2);
    valid = 1'b1; data = MC3[95:64]; tick();
    valid = 1'b0; data = 32'hFFFFFFFF; tick(); tick();
    chk("t3_ent_ready_gap", ent_ready, 1);
    valid = 1'b1; data = MC3[127:96]; tick();
    valid = 1'b0;
    chk("t3_ent_ready_off", ent_ready, 0);
    chk("t3_start", start, 1);
    chk("t3_mc", mc, MC3);
    finish_fill();

    // Precompute never finishes: timeout
    req = 1'b1; tick(); req = 1'b0;
    send4(MC4);
    chk("t4_start", start, 1);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t4_err_not_yet", err, 0);
    chk("t4_busy_pre", busy, 1);
    tick();
    chk("t4_err", err, 1);
    chk("t4_idle_busy", busy, 0);
    chk("t4_ready", ready, 0);
    chk("t4_ent_ready", ent_ready, 0);
    tick();
    chk("t4_err_sticky", err, 1);
    req = 1'b1; tick(); req = 1'b0;
    chk("t4_err_clear", err, 0);
    chk("t4_busy_again", busy, 1);

    // Request during WAIT_DONE is ignored, not queued
    send4(MC5);
    tick();
    req = 1'b1; tick(); req = 1'b0;
    chk("t5_busy_wait", busy, 1);
    chk("t5_no_collect", ent_ready, 0);
    finish_fill();
    tick();
    chk("t5_ready_held", ready, 1);
    chk("t5_not_requeued", busy, 0);
    enc = 1'b1; req = 1'b1; tick(); req = 1'b0; enc = 1'b0;
    chk("t5_ready_drop", ready, 0);
    send4(MC6);
    chk("t5_enc_dec", enc_o, 1);
    chk("t5_mc", mc, MC6);
    tick();
    chk("t5_ready_wait", ready, 0);
    finish_fill();

    // Async reset mid-collection, then restart from word 0
    req = 1'b1; tick(); req = 1'b0;
    send(32'hE4E3E2E1); send(32'h00E5E6E7); send(32'hF4F3F2F1);
    chk("t6_rej_pre", rej, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mc", mc, 0);
    chk("t6_enc", enc_o, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", ready, 0);
    chk("t6_ent_ready", ent_ready, 0);
    chk("t6_rej", rej, 0);
    chk("t6_start", start, 0);
    tick();
    rst_n = 1'b1;
    tick();
    req = 1'b1; tick(); req = 1'b0;
    send4(MC7);
    chk("t6_restart_mc", mc, MC7);
    chk("t6_restart_start", start, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
